// File: rtl/execute_mc.sv
// execute_mc: registered LEGv8 execute stage with ALU, branch target and iterative shift-add multiplier
//   in : clk, reset (async, active-high), valid_E, flush_E, AluSrc, AluControl[3:0], MulOp,
//        PC_E, signImm_E, readData1_E, readData2_E [N-1:0]
//   out: stall_E, valid_M, PCBranch_M, aluResult_M, writeData_M [N-1:0], zero_M
module execute_mc #(
  parameter int N        = 64,
  parameter int BR_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic         MulOp,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         stall_E,
  output logic         valid_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, MUL} state_t;
  state_t         r_state, w_next;
  logic [N-1:0]   r_mcand, r_mplier, r_acc, r_pc, r_imm, r_wd;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   w_b, w_alu, w_pcb, w_pcb_l, w_prod;
  logic           w_last, w_issue;
  assign w_b     = AluSrc ? signImm_E : readData2_E;
  assign w_alu   = AluControl == 4'b0000 ? readData1_E & w_b :
                   AluControl == 4'b0001 ? readData1_E | w_b :
                   AluControl == 4'b0010 ? readData1_E + w_b :
                   AluControl == 4'b0110 ? readData1_E - w_b :
                   AluControl == 4'b0111 ? w_b :
                   AluControl == 4'b1100 ? ~(readData1_E | w_b) : '0;
  assign w_pcb   = PC_E + (signImm_E << BR_SHIFT);
  assign w_pcb_l = r_pc + (r_imm << BR_SHIFT);
  assign w_prod  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last  = r_state == MUL && r_cnt == CW'(N - 1);
  assign w_issue = r_state == IDLE && valid_E && MulOp && !flush_E;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb
    w_next = flush_E ? IDLE :
             r_state == IDLE ? (w_issue ? MUL : IDLE) :
             (w_last ? IDLE : MUL);
  // reset gates stall immediately so upstream is released without waiting for an edge
  always_comb
    stall_E = !reset && !flush_E &&
              ((r_state == IDLE && valid_E && MulOp) || (r_state == MUL && !w_last));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_wd        <= '0;
      r_cnt       <= '0;
      valid_M     <= 1'b0;
      PCBranch_M  <= '0;
      aluResult_M <= '0;
      writeData_M <= '0;
      zero_M      <= 1'b0;
    end else if (flush_E) begin
      valid_M <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (valid_E && !MulOp) begin
        aluResult_M <= w_alu;
        PCBranch_M  <= w_pcb;
        writeData_M <= readData2_E;
        zero_M      <= w_alu == '0;
        valid_M     <= 1'b1;
      end else if (w_issue) begin
        r_mcand  <= readData1_E;
        r_mplier <= w_b;
        r_pc     <= PC_E;
        r_imm    <= signImm_E;
        r_wd     <= readData2_E;
        r_acc    <= '0;
        r_cnt    <= '0;
        valid_M  <= 1'b0;
      end else begin
        valid_M <= 1'b0;
      end
    end else begin
      r_acc    <= w_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        aluResult_M <= w_prod;
        PCBranch_M  <= w_pcb_l;
        writeData_M <= r_wd;
        zero_M      <= w_prod == '0;
        valid_M     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: directed self-checking bench for execute_mc (N=64 and N=8 instances)
module tb_execute_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_E = 1'b0, flush_E = 1'b0, AluSrc = 1'b0, MulOp = 1'b0;
  logic [3:0]  AluControl = 4'b0000;
  logic [63:0] PC_E = '0, signImm_E = '0, rd1 = '0, rd2 = '0;
  logic        stall_E, valid_M, zero_M;
  logic [63:0] PCBranch_M, aluResult_M, writeData_M;
  logic        v8 = 1'b0, m8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        s8, vm8, z8;
  logic [7:0]  pcb8, r8, wd8;
  int total = 0;
  int bad = 0;

  execute_mc #(.N(64), .BR_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E), .AluSrc(AluSrc),
    .AluControl(AluControl), .MulOp(MulOp), .PC_E(PC_E), .signImm_E(signImm_E),
    .readData1_E(rd1), .readData2_E(rd2), .stall_E(stall_E), .valid_M(valid_M),
    .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M), .writeData_M(writeData_M),
    .zero_M(zero_M)
  );

  execute_mc #(.N(8), .BR_SHIFT(2)) dut8 (
    .clk(clk), .reset(reset), .valid_E(v8), .flush_E(1'b0), .AluSrc(1'b0),
    .AluControl(4'b0000), .MulOp(m8), .PC_E(8'h00), .signImm_E(8'h00),
    .readData1_E(a8), .readData2_E(b8), .stall_E(s8), .valid_M(vm8),
    .PCBranch_M(pcb8), .aluResult_M(r8), .writeData_M(wd8), .zero_M(z8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input string tag, input logic [3:0] code, input logic src,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc,
                     input logic [63:0] imm, input logic [63:0] exp);
    valid_E = 1'b1; MulOp = 1'b0; AluControl = code; AluSrc = src;
    rd1 = a; rd2 = b; PC_E = pc; signImm_E = imm;
    #1;
    chk({tag, "_stall"}, {63'd0, stall_E}, 64'd0);
    step();
    chk({tag, "_valid"}, {63'd0, valid_M}, 64'd1);
    chk({tag, "_res"}, aluResult_M, exp);
    chk({tag, "_zero"}, {63'd0, zero_M}, {63'd0, exp == 64'd0});
    chk({tag, "_pcb"}, PCBranch_M, pc + (imm << 2));
    chk({tag, "_wd"}, writeData_M, b);
  endtask

  task automatic mul64(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp);
    valid_E = 1'b1; MulOp = 1'b1; AluSrc = 1'b0; AluControl = 4'b0010;
    rd1 = a; rd2 = b; PC_E = 64'h200; signImm_E = 64'd1;
    #1;
    chk({tag, "_stall_t0"}, {63'd0, stall_E}, 64'd1);
    step();
    PC_E = 64'hDEAD; rd1 = 64'd3; rd2 = 64'd3;
    chk({tag, "_stall"}, {63'd0, stall_E}, 64'd1);
    chk({tag, "_bubble"}, {63'd0, valid_M}, 64'd0);
    for (int k = 2; k < 64; k++) begin
      step();
      chk({tag, "_stall"}, {63'd0, stall_E}, 64'd1);
      chk({tag, "_bubble"}, {63'd0, valid_M}, 64'd0);
    end
    step();
    chk({tag, "_stall_last"}, {63'd0, stall_E}, 64'd0);
    chk({tag, "_bubble_last"}, {63'd0, valid_M}, 64'd0);
    valid_E = 1'b0; MulOp = 1'b0;
    step();
    chk({tag, "_valid"}, {63'd0, valid_M}, 64'd1);
    chk({tag, "_res"}, aluResult_M, exp);
    chk({tag, "_zero"}, {63'd0, zero_M}, {63'd0, exp == 64'd0});
    chk({tag, "_pcb"}, PCBranch_M, 64'h204);
    chk({tag, "_wd"}, writeData_M, b);
  endtask

  initial begin
    #1;
    chk("rst_valid", {63'd0, valid_M}, 64'd0);
    chk("rst_res", aluResult_M, 64'd0);
    chk("rst_pcb", PCBranch_M, 64'd0);
    chk("rst_stall", {63'd0, stall_E}, 64'd0);
    #11 reset = 1'b0;
    alu("add", 4'b0010, 1'b0, 64'd5, 64'd7, 64'h100, 64'd3, 64'd12);
    chk("add_pcb_abs", PCBranch_M, 64'h10C);
    alu("sub_eq", 4'b0110, 1'b0, 64'd9, 64'd9, 64'h0, 64'd0, 64'd0);
    alu("sub_neg", 4'b0110, 1'b0, 64'd0, 64'd1, 64'h40, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    alu("nor", 4'b1100, 1'b0, 64'd0, 64'd0, 64'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    alu("and", 4'b0000, 1'b0, 64'hF0F0, 64'h0FF0, 64'h8, 64'd2, 64'h00F0);
    alu("or", 4'b0001, 1'b0, 64'hF000, 64'h000F, 64'h8, 64'd2, 64'hF00F);
    alu("passb", 4'b0111, 1'b0, 64'h1234, 64'h55, 64'h0, 64'd0, 64'h55);
    alu("bad_op", 4'b1111, 1'b0, 64'd3, 64'd4, 64'h0, 64'd0, 64'd0);
    valid_E = 1'b1; MulOp = 1'b0; AluControl = 4'b0010; AluSrc = 1'b1;
    rd1 = 64'd10; rd2 = 64'd99; PC_E = 64'h0; signImm_E = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk("imm_add_res", aluResult_M, 64'd9);
    chk("imm_add_pcb", PCBranch_M, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("imm_add_wd", writeData_M, 64'd99);
    valid_E = 1'b0;
    step();
    chk("idle_valid", {63'd0, valid_M}, 64'd0);
    chk("idle_hold", aluResult_M, 64'd9);
    mul64("mul42", 64'd6, 64'd7, 64'd42);
    mul64("mul_ovf", 64'h8000_0000_0000_0000, 64'd2, 64'd0);
    valid_E = 1'b1; MulOp = 1'b1; rd1 = 64'd6; rd2 = 64'd7;
    for (int k = 0; k < 10; k++) step();
    chk("fl_pre_stall", {63'd0, stall_E}, 64'd1);
    flush_E = 1'b1;
    #1;
    chk("fl_stall", {63'd0, stall_E}, 64'd0);
    step();
    flush_E = 1'b0;
    chk("fl_valid", {63'd0, valid_M}, 64'd0);
    chk("fl_hold", aluResult_M, 64'd0);
    alu("fl_add", 4'b0010, 1'b0, 64'd3, 64'd4, 64'h10, 64'd1, 64'd7);
    valid_E = 1'b1; MulOp = 1'b1; rd1 = 64'd3; rd2 = 64'd5;
    step();
    step();
    step();
    #3 reset = 1'b1;
    #1;
    chk("ar_valid", {63'd0, valid_M}, 64'd0);
    chk("ar_res", aluResult_M, 64'd0);
    chk("ar_pcb", PCBranch_M, 64'd0);
    chk("ar_wd", writeData_M, 64'd0);
    chk("ar_zero", {63'd0, zero_M}, 64'd0);
    chk("ar_stall", {63'd0, stall_E}, 64'd0);
    #2 reset = 1'b0;
    alu("ar_add", 4'b0010, 1'b0, 64'd1, 64'd1, 64'h0, 64'd0, 64'd2);
    valid_E = 1'b0;
    v8 = 1'b1; m8 = 1'b1; a8 = 8'h10; b8 = 8'h11;
    #1;
    chk("m8_stall_t0", {63'd0, s8}, 64'd1);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("m8_stall", {63'd0, s8}, 64'd1);
      chk("m8_bubble", {63'd0, vm8}, 64'd0);
    end
    step();
    chk("m8_stall_last", {63'd0, s8}, 64'd0);
    v8 = 1'b0; m8 = 1'b0;
    step();
    chk("m8_valid", {63'd0, vm8}, 64'd1);
    chk("m8_res", {56'd0, r8}, 64'h10);
    chk("m8_zero", {63'd0, z8}, 64'd0);
    chk("m8_wd", {56'd0, wd8}, 64'h11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/execute_mc.md
# execute_mc

Registered, parametrised execute stage for the pipelined LEGv8 datapath. It computes ALU results and branch targets in one cycle and captures them in an internal EX/MEM output register. It adds an iterative shift-add multiplier that takes N cycles and stalls upstream stages through `stall_E`. A synchronous flush input squashes the in-flight instruction for branch mispredicts.

## Interface
- `N`, default 64: datapath width in bits; legal range 8..64.
- `BR_SHIFT`, default 2: left shift applied to `signImm_E` when forming the branch target.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-high; clears all state.
- `valid_E  in  1`: an instruction is present in EX.
- `flush_E  in  1`: squash the instruction in EX and abort any multiply.
- `AluSrc  in  1`: 0 selects `readData2_E` as operand B; 1 selects `signImm_E`.
- `AluControl  in  4`: ALU operation code.
- `MulOp  in  1`: the instruction is MUL; overrides `AluControl`.
- `PC_E`, `signImm_E`, `readData1_E`, `readData2_E`  `in  N`: EX operands.
- `stall_E  out  1`: upstream must hold EX inputs stable.
- `valid_M  out  1`: the output register holds a valid result.
- `PCBranch_M  out  N`: registered value of `PC_E + (signImm_E << BR_SHIFT)`, truncated to N bits.
- `aluResult_M  out  N`: registered ALU result or product.
- `writeData_M  out  N`: registered value of `readData2_E`.
- `zero_M  out  1`: registered flag, set when `aluResult_M == 0`.

## Operation
- Operand B: B = `AluSrc ? signImm_E : readData2_E`.
- ALU codes, all modulo 2^N:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A−B), 0111 pass B, 1100 NOR.
  - Any other code produces 0.
- FSM states: IDLE, MUL.
- IDLE, with `valid_E` & !`MulOp` & !`flush_E`:
  - The edge loads the output register with the ALU result, PCBranch, writeData and zero.
  - `valid_M` becomes 1.
- IDLE, with `valid_E` & `MulOp` & !`flush_E`:
  - The edge latches multiplicand = A, multiplier = B, and PC/signImm/readData2.
  - The accumulator and the counter `cnt` are cleared.
  - The state becomes MUL and `valid_M` becomes 0 (bubble).
- IDLE, with !`valid_E`: `valid_M` becomes 0; the other output fields hold their values.
- MUL, each cycle:
  - If multiplier[0] is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1.
  - Increment `cnt`. Arithmetic is N bits and keeps only the low N bits of the product.
- MUL, when `cnt == N-1`:
  - The final iteration result is written to `aluResult_M` at the edge.
  - PCBranch_M and writeData_M take the latched values; zero_M is set from the product.
  - `valid_M` becomes 1 and the state returns to IDLE.
- The EX inputs are ignored while in MUL; only the latched copies are used.
- `stall_E` = (IDLE & `valid_E` & `MulOp` & !`flush_E`) | (MUL & `cnt != N-1` & !`flush_E`).
- `flush_E` takes priority over everything:
  - The next edge sets `valid_M` to 0 and the state to IDLE, with `cnt` cleared.
  - The other output fields hold their values.
  - `stall_E` is 0 during the flush cycle.
- `reset`, asserted at any time including mid-multiply:
  - All outputs and `cnt` go to 0 immediately and the state goes to IDLE.
  - `stall_E` goes to 0 combinationally.

## Timing
- ALU ops: one-cycle latency. Inputs in cycle t give the result on `*_M` in cycle t+1.
- Back-to-back ALU ops run at full throughput with no stall.
- MUL presented in cycle t:
  - `stall_E` is high in cycles t..t+N-1.
  - The product appears on `aluResult_M` with `valid_M` = 1 in cycle t+N+1.
  - `valid_M` is 0 in cycles t+1..t+N.
- The cycle where `cnt == N-1` has `stall_E` = 0. At that edge the upstream advances and the next instruction is in EX in cycle t+N+1.
- A MUL immediately after a MUL restarts the FSM from IDLE, with the same latency.
- Outputs are reset to 0 and change only on clock edges, except on asynchronous reset.
- `stall_E` is combinational from `valid_E`, `MulOp`, `flush_E` and the state.

## Test plan
- Reset, then ADD with A=5, B=7 (`AluSrc`=0), `PC_E`=0x100, `signImm_E`=3 -> next cycle `aluResult_M`=12, `PCBranch_M`=0x10C, `valid_M`=1, `zero_M`=0.
- SUB with A=9, B=9 -> `aluResult_M`=0, `zero_M`=1. SUB with A=0, B=1 -> 0xFFFF_FFFF_FFFF_FFFF (N=64). NOR with A=B=0 -> all ones.
- MUL with A=6, B=7, N=64 -> `stall_E` high 64 cycles, `valid_M` low 64 cycles, then `aluResult_M`=42 with `valid_M`=1 on the 65th cycle after issue. MUL with A=2^63, B=2 -> 0 and `zero_M`=1.
- N=8 instance, MUL with A=0x10, B=0x11 -> `aluResult_M`=0x10 (low 8 bits of 0x110). `stall_E` is high for exactly 8 cycles.
- `flush_E` asserted on MUL cycle 10 -> `stall_E`=0 that cycle and `valid_M`=0 next cycle. A following ADD completes one cycle later with the correct result.
- `reset` pulsed mid-multiply, asynchronously between edges -> all outputs 0 immediately and `stall_E`=0. After release, ADD with A=1, B=1 yields 2 in one cycle.
